// File: rtl/timer_bank.sv
// timer_bank: memory-mapped 64-bit machine timer with prescaler, NUM_CMP
// compare channels, sticky W1C pending bits and per-channel interrupt enables.
// Optional build macro: TIMER_SNAPSHOT_EN -- a MTIME_LO read latches
// mtime[63:32] so a following MTIME_HI read returns a coherent pair.
module timer_bank #(
   parameter logic [31:0] BASE_ADDR  = 32'hFFFF0000,
   parameter int          NUM_CMP    = 4,
   parameter int          PRESCALE_W = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [31:0]         address,
   input  logic [31:0]         write_data,
   input  logic                write_enable,
   output logic [31:0]         read_data,
   output logic [NUM_CMP-1:0]  interrupt
);

   logic [31:0]           offset;
   logic                  in_win;
   logic [5:0]            word;
   logic                  sel_lo, sel_hi, sel_ctrl, sel_pend, sel_irqen;
   logic [NUM_CMP-1:0]    sel_cmp_lo, sel_cmp_hi;

   logic [63:0]           mtime;
   logic [63:0]           cmp [NUM_CMP];
   logic                  en;
   logic [PRESCALE_W-1:0] div;
   logic [PRESCALE_W-1:0] pcount;
   logic [NUM_CMP-1:0]    pending;
   logic [NUM_CMP-1:0]    irq_en;
   logic [NUM_CMP-1:0]    match;
   logic                  tick;
   logic [31:0]           hi_rd;
   logic [NUM_CMP-1:0]    pend_clr;

   // Word decode of the register window; non-word-aligned addresses map nowhere.
   always_comb begin
      offset     = address - BASE_ADDR;
      in_win     = (offset[31:8] == 24'd0) && (offset[1:0] == 2'b00);
      word       = offset[7:2];
      sel_lo     = in_win && (word == 6'd0);
      sel_hi     = in_win && (word == 6'd1);
      sel_ctrl   = in_win && (word == 6'd2);
      sel_pend   = in_win && (word == 6'd3);
      sel_irqen  = in_win && (word == 6'd4);
      sel_cmp_lo = '0;
      sel_cmp_hi = '0;
      for (int i = 0; i < NUM_CMP; i++) begin
         sel_cmp_lo[i] = in_win && (word == 6'(8 + 2*i));
         sel_cmp_hi[i] = in_win && (word == 6'(9 + 2*i));
      end
   end

   // Prescaler terminal count; EN low suppresses the tick entirely.
   always_comb begin
      tick = en && (pcount == div);
   end

   // Control register, prescale counter and mtime; a bus write to either
   // mtime half takes precedence over the increment of that cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         mtime  <= '0;
         pcount <= '0;
         en     <= 1'b1;
         div    <= '0;
      end else begin
         if (write_enable && sel_ctrl) begin
            en  <= write_data[0];
            div <= write_data[16 +: PRESCALE_W];
         end
         if (write_enable && (sel_lo || sel_hi || sel_ctrl))
            pcount <= '0;
         else if (en)
            pcount <= tick ? '0 : pcount + PRESCALE_W'(1);
         if (write_enable && sel_lo)
            mtime[31:0] <= write_data;
         if (write_enable && sel_hi)
            mtime[63:32] <= write_data;
         if (!(write_enable && (sel_lo || sel_hi)) && tick)
            mtime <= mtime + 64'd1;
      end
   end

   // Compare registers, written a half at a time.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_CMP; i++) begin
         if (rst)
            cmp[i] <= '1;
         else begin
            if (write_enable && sel_cmp_lo[i]) cmp[i][31:0]  <= write_data;
            if (write_enable && sel_cmp_hi[i]) cmp[i][63:32] <= write_data;
         end
      end
   end

   // Unsigned compare against the registered mtime.
   always_comb begin
      match = '0;
      for (int i = 0; i < NUM_CMP; i++)
         match[i] = (mtime >= cmp[i]);
   end

   // Write-one-to-clear mask for the pending bits.
   always_comb begin
      pend_clr = (write_enable && sel_pend) ? write_data[NUM_CMP-1:0] : '0;
   end

   // Sticky pending bits (set beats clear) and interrupt enables.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending <= '0;
         irq_en  <= '0;
      end else begin
         pending <= match | (pending & ~pend_clr);
         if (write_enable && sel_irqen)
            irq_en <= write_data[NUM_CMP-1:0];
      end
   end

`ifdef TIMER_SNAPSHOT_EN
   logic [31:0] snapshot;

   // Latch the upper half whenever software reads the lower half.
   always_ff @(posedge clk) begin
      if (rst)
         snapshot <= '0;
      else if (sel_lo && !write_enable)
         snapshot <= mtime[63:32];
   end

   assign hi_rd = snapshot;
`else
   assign hi_rd = mtime[63:32];
`endif

   // Combinational read mux; unmapped words and unused bits read as zero.
   always_comb begin
      read_data = '0;
      if (sel_lo)    read_data = mtime[31:0];
      if (sel_hi)    read_data = hi_rd;
      if (sel_ctrl) begin
         read_data[0]                 = en;
         read_data[16 +: PRESCALE_W]  = div;
      end
      if (sel_pend)  read_data[NUM_CMP-1:0] = pending;
      if (sel_irqen) read_data[NUM_CMP-1:0] = irq_en;
      for (int i = 0; i < NUM_CMP; i++) begin
         if (sel_cmp_lo[i]) read_data = cmp[i][31:0];
         if (sel_cmp_hi[i]) read_data = cmp[i][63:32];
      end
   end

   assign interrupt = pending & irq_en;

endmodule

// File: tb/tb_timer_bank.sv
// Testbench for timer_bank: a register-level vector table followed by
// hand-written multi-cycle sequences; expected values go through a scoreboard.
module tb_timer_bank;

   localparam int NUM_CMP = 4;
   localparam logic [31:0] BASE    = 32'hFFFF0000;
   localparam logic [31:0] A_LO    = BASE + 32'h00;
   localparam logic [31:0] A_HI    = BASE + 32'h04;
   localparam logic [31:0] A_CTRL  = BASE + 32'h08;
   localparam logic [31:0] A_PEND  = BASE + 32'h0C;
   localparam logic [31:0] A_IRQEN = BASE + 32'h10;
   localparam logic [31:0] A_IDLE  = BASE + 32'h14;

   logic               clk = 1'b0;
   logic               rst;
   logic [31:0]        address;
   logic [31:0]        write_data;
   logic               write_enable;
   logic [31:0]        read_data;
   logic [NUM_CMP-1:0] interrupt;

   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        we;
      logic [31:0] exp_rd;
      logic [3:0]  exp_irq;
   } vec_t;

   typedef struct {
      string       name;
      logic        is_irq;
      logic [31:0] exp;
   } sb_t;

   vec_t vecs[20];
   sb_t  sb[$];

   timer_bank #(.BASE_ADDR(BASE), .NUM_CMP(NUM_CMP), .PRESCALE_W(16)) dut (
      .clk(clk), .rst(rst), .address(address), .write_data(write_data),
      .write_enable(write_enable), .read_data(read_data), .interrupt(interrupt)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] a_cmp_lo(int i);
      return BASE + 32'h20 + 32'(8*i);
   endfunction

   function automatic logic [31:0] a_cmp_hi(int i);
      return BASE + 32'h24 + 32'(8*i);
   endfunction

   task automatic apply(input logic [31:0] a, input logic [31:0] d, input logic w);
      address      = a;
      write_data   = d;
      write_enable = w;
   endtask

   task automatic next_cycle();
      @(negedge clk);
   endtask

   task automatic push_rd(input string name, input logic [31:0] e);
      sb.push_back('{name, 1'b0, e});
   endtask

   task automatic push_irq(input string name, input logic [3:0] e);
      sb.push_back('{name, 1'b1, {28'd0, e}});
   endtask

   // Pop every pending expectation and compare against the DUT outputs now.
   task automatic drain();
      sb_t         s;
      logic [31:0] act;
      #1;
      while (sb.size() > 0) begin
         s   = sb.pop_front();
         act = s.is_irq ? {28'd0, interrupt} : read_data;
         n_vec++;
         if (act !== s.exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", s.name, act, s.exp);
         end
      end
   endtask

   task automatic rd(input logic [31:0] a, input string name, input logic [31:0] e);
      apply(a, 32'd0, 1'b0);
      push_rd(name, e);
      drain();
      next_cycle();
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      apply(a, d, 1'b1);
      next_cycle();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         apply(A_IDLE, 32'd0, 1'b0);
         next_cycle();
      end
   endtask

   initial begin
      logic found;

      vecs[0]  = '{A_LO,          32'd0,         1'b0, 32'd0,         4'd0};
      vecs[1]  = '{A_LO,          32'd0,         1'b0, 32'd1,         4'd0};
      vecs[2]  = '{A_LO,          32'd0,         1'b0, 32'd2,         4'd0};
      vecs[3]  = '{A_HI,          32'd0,         1'b0, 32'd0,         4'd0};
      vecs[4]  = '{A_CTRL,        32'd0,         1'b0, 32'd1,         4'd0};
      vecs[5]  = '{A_PEND,        32'd0,         1'b0, 32'd0,         4'd0};
      vecs[6]  = '{A_IRQEN,       32'd0,         1'b0, 32'd0,         4'd0};
      vecs[7]  = '{a_cmp_lo(0),   32'd0,         1'b0, 32'hFFFFFFFF,  4'd0};
      vecs[8]  = '{a_cmp_hi(3),   32'd0,         1'b0, 32'hFFFFFFFF,  4'd0};
      vecs[9]  = '{BASE + 32'h14, 32'd0,         1'b0, 32'd0,         4'd0};
      vecs[10] = '{A_IRQEN,       32'hFFFFFFFF,  1'b1, 32'd0,         4'd0};
      vecs[11] = '{A_IRQEN,       32'd0,         1'b0, 32'h0000000F,  4'd0};
      vecs[12] = '{BASE + 32'h18, 32'h12345678,  1'b1, 32'd0,         4'd0};
      vecs[13] = '{BASE + 32'h18, 32'd0,         1'b0, 32'd0,         4'd0};
      vecs[14] = '{A_CTRL,        32'h0000FFFE,  1'b1, 32'd1,         4'd0};
      vecs[15] = '{A_CTRL,        32'd0,         1'b0, 32'd0,         4'd0};
      vecs[16] = '{A_LO,          32'd0,         1'b0, 32'd15,        4'd0};
      vecs[17] = '{A_LO,          32'd0,         1'b0, 32'd15,        4'd0};
      vecs[18] = '{a_cmp_lo(NUM_CMP), 32'd0,     1'b0, 32'd0,         4'd0};
      vecs[19] = '{32'h00000000,  32'd0,         1'b0, 32'd0,         4'd0};

      rst = 1'b1;
      apply(A_IDLE, 32'd0, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Register-level vectors, one per cycle, starting right out of reset.
      for (int k = 0; k < 20; k++) begin
         apply(vecs[k].addr, vecs[k].wdata, vecs[k].we);
         push_rd($sformatf("vec%0d read_data", k), vecs[k].exp_rd);
         push_irq($sformatf("vec%0d interrupt", k), vecs[k].exp_irq);
         drain();
         next_cycle();
      end

      // Prescaler DIV=3: 20 cycles -> 5 increments, then EN=0 freezes.
      wr(A_CTRL, 32'h0003_0000);
      wr(A_LO, 32'd0);
      wr(A_HI, 32'd0);
      wr(A_CTRL, 32'h0003_0001);
      idle(20);
      rd(A_LO, "div3 run20", 32'd5);
      wr(A_CTRL, 32'h0003_0000);
      idle(10);
      rd(A_LO, "div3 frozen", 32'd5);

      // Compare channel 0 at 10 with interrupt enabled.
      wr(A_CTRL, 32'h0);
      wr(A_LO, 32'd0);
      wr(A_IRQEN, 32'd1);
      wr(a_cmp_hi(0), 32'd0);
      wr(a_cmp_lo(0), 32'd10);
      wr(A_CTRL, 32'h1);
      found = 1'b0;
      for (int k = 0; k < 50 && !found; k++) begin
         apply(A_LO, 32'd0, 1'b0);
         #1;
         if (read_data == 32'd10) begin
            found = 1'b1;
            push_irq("cmp0 irq at match", 4'b0000);
            drain();
            next_cycle();
            apply(A_PEND, 32'd0, 1'b0);
            push_rd("cmp0 pending +1clk", 32'd1);
            push_irq("cmp0 irq +1clk", 4'b0001);
            drain();
         end
         next_cycle();
      end
      if (!found) begin
         n_vec++;
         n_bad++;
         $display("FAIL cmp0 wait: got timeout, want mtime==10");
      end
      wr(A_PEND, 32'd1);
      rd(A_PEND, "w1c during match", 32'd1);
      wr(a_cmp_hi(0), 32'hFFFFFFFF);
      wr(A_PEND, 32'd1);
      rd(A_PEND, "w1c after disarm", 32'd0);

      // 64-bit wrap, masked channels, write beats increment.
      wr(A_CTRL, 32'h0);
      wr(A_LO, 32'hFFFFFFFF);
      wr(A_HI, 32'hFFFFFFFF);
      wr(A_CTRL, 32'h1);
      rd(A_LO, "wrap pre", 32'hFFFFFFFF);
      rd(A_LO, "wrap lo", 32'd0);
      apply(A_HI, 32'd0, 1'b0);
      push_rd("wrap hi", 32'd0);
      push_irq("wrap irq masked", 4'b0001);
      drain();
      next_cycle();
      wr(A_PEND, 32'hF);
      rd(A_PEND, "wrap clear", 32'd0);
      wr(A_LO, 32'h100);
      rd(A_LO, "write beats inc", 32'h100);
      rd(A_LO, "inc after write", 32'h101);
      wr(A_HI, 32'h5);
      rd(A_LO, "hi write keeps lo", 32'h102);
      rd(A_HI, "hi write value", 32'h5);
      wr(A_CTRL, 32'h0);
      wr(A_HI, 32'h0);

      // Same-cycle set and clear on ch1; ch2 pending with its enable off.
      wr(a_cmp_hi(1), 32'd0);
      wr(a_cmp_lo(1), 32'd0);
      wr(A_PEND, 32'd2);
      rd(A_PEND, "set beats clear", 32'd2);
      wr(a_cmp_hi(2), 32'd0);
      wr(a_cmp_lo(2), 32'd0);
      idle(1);
      apply(A_PEND, 32'd0, 1'b0);
      push_rd("ch2 pending", 32'd6);
      push_irq("ch2 masked", 4'b0000);
      drain();
      next_cycle();
      wr(A_IRQEN, 32'd4);
      apply(A_IDLE, 32'd0, 1'b0);
      push_irq("ch2 enabled", 4'b0100);
      drain();
      next_cycle();

      // Reset in the middle of operation.
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      apply(A_LO, 32'd0, 1'b0);
      push_rd("reset mtime", 32'd0);
      push_irq("reset irq", 4'b0000);
      drain();
      next_cycle();
      rd(A_PEND, "reset pending", 32'd0);
      rd(a_cmp_lo(1), "reset cmp1", 32'hFFFFFFFF);
      rd(A_IRQEN, "reset irq_en", 32'd0);

      // LO-then-HI read across a carry into the upper half.
      wr(A_CTRL, 32'h0);
      wr(A_LO, 32'hFFFFFFFE);
      wr(A_HI, 32'h0);
      wr(A_CTRL, 32'h1);
      rd(A_LO, "snap lo", 32'hFFFFFFFE);
      idle(4);
`ifdef TIMER_SNAPSHOT_EN
      rd(A_HI, "snap hi", 32'd0);
`else
      rd(A_HI, "live hi", 32'd1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
